ras_ckpt: RTL

- Parametrised return address stack for the fetch stage with flush recovery.
- Holds a speculative stack, updated by fetch-time call/return predictions, and a committed stack, updated by retiring call/return instructions.
- On a pipeline flush, the speculative stack is restored from the committed stack in one cycle.
- Both stacks are circular buffers with a top pointer and an occupancy counter. Overflow overwrites the oldest entry.

---
 rtl/ras_ckpt_pkg.sv | 25 ++
 rtl/ras_stack_core.sv | 55 +++++
 rtl/ras_ckpt.sv | 99 +++++++++
 3 files changed

// File: rtl/ras_ckpt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ras_ckpt_pkg
// Purpose  : Shared types for the checkpointed return address stack.
// Revision : 1.0 - initial release
// ============================================================================
package ras_ckpt_pkg;

  localparam int C_VIRT_W          = 32;
  localparam int C_RAS_ENTRIES_NUM = 8;
  localparam int C_RAS_PTR_W       = $clog2(C_RAS_ENTRIES_NUM);
  localparam int C_RAS_CNT_W       = $clog2(C_RAS_ENTRIES_NUM + 1);

  typedef logic [C_VIRT_W-1:0] virt_t;

  typedef struct packed {
    logic  valid;
    virt_t data;
  } ras_t;

  typedef logic [C_RAS_PTR_W-1:0] ras_ptr_t;
  typedef logic [C_RAS_CNT_W-1:0] ras_cnt_t;

endpackage
`default_nettype wire

// File: rtl/ras_stack_core.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack_core
// Purpose  : Combinational next-state of one circular return address stack.
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack_core
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES_NUM = 8,
  parameter int PTR_W       = $clog2(ENTRIES_NUM),
  parameter int CNT_W       = $clog2(ENTRIES_NUM + 1)
) (
  input  virt_t [ENTRIES_NUM-1:0] cur_entries,
  input  logic  [PTR_W-1:0]       cur_ptr,
  input  logic  [CNT_W-1:0]       cur_count,
  input  logic                    push,
  input  logic                    pop,
  input  virt_t                   data,
  output virt_t [ENTRIES_NUM-1:0] nxt_entries,
  output logic  [PTR_W-1:0]       nxt_ptr,
  output logic  [CNT_W-1:0]       nxt_count
);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(ENTRIES_NUM);

  logic [PTR_W-1:0] w_ptr_inc;

  always_comb begin
    nxt_entries = cur_entries;
    nxt_ptr     = cur_ptr;
    nxt_count   = cur_count;
    w_ptr_inc   = cur_ptr + PTR_W'(1);

    if (push && pop) begin
      // Call replacing a return: overwrite the top in place.
      nxt_entries[cur_ptr] = data;
      if (cur_count == '0) begin
        nxt_count = CNT_W'(1);
      end
    end else if (push) begin
      // Pointer wraps naturally; a full stack loses its oldest entry.
      nxt_ptr                = w_ptr_inc;
      nxt_entries[w_ptr_inc] = data;
      if (cur_count != C_FULL) begin
        nxt_count = cur_count + CNT_W'(1);
      end
    end else if (pop && (cur_count != '0)) begin
      nxt_ptr   = cur_ptr - PTR_W'(1);
      nxt_count = cur_count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ras_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : ras_ckpt
// Purpose  : Speculative + committed return address stack with flush restore.
// Revision : 1.0 - initial release
// ============================================================================
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES_NUM = C_RAS_ENTRIES_NUM
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  push_req,
  input  logic  pop_req,
  input  virt_t push_data,
  input  logic  commit_push_req,
  input  logic  commit_pop_req,
  input  virt_t commit_push_data,
  output ras_t  ras_top,
  output logic [$clog2(ENTRIES_NUM+1)-1:0] ras_count
);

  localparam int PTR_W = $clog2(ENTRIES_NUM);
  localparam int CNT_W = $clog2(ENTRIES_NUM + 1);

  virt_t [ENTRIES_NUM-1:0] r_spec_entries, w_spec_entries_nxt;
  logic  [PTR_W-1:0]       r_spec_ptr,     w_spec_ptr_nxt;
  logic  [CNT_W-1:0]       r_spec_count,   w_spec_count_nxt;

  virt_t [ENTRIES_NUM-1:0] r_cmt_entries,  w_cmt_entries_nxt;
  logic  [PTR_W-1:0]       r_cmt_ptr,      w_cmt_ptr_nxt;
  logic  [CNT_W-1:0]       r_cmt_count,    w_cmt_count_nxt;

  ras_stack_core #(
    .ENTRIES_NUM (ENTRIES_NUM),
    .PTR_W       (PTR_W),
    .CNT_W       (CNT_W)
  ) u_spec_core (
    .cur_entries (r_spec_entries),
    .cur_ptr     (r_spec_ptr),
    .cur_count   (r_spec_count),
    .push        (push_req),
    .pop         (pop_req),
    .data        (push_data),
    .nxt_entries (w_spec_entries_nxt),
    .nxt_ptr     (w_spec_ptr_nxt),
    .nxt_count   (w_spec_count_nxt)
  );

  ras_stack_core #(
    .ENTRIES_NUM (ENTRIES_NUM),
    .PTR_W       (PTR_W),
    .CNT_W       (CNT_W)
  ) u_cmt_core (
    .cur_entries (r_cmt_entries),
    .cur_ptr     (r_cmt_ptr),
    .cur_count   (r_cmt_count),
    .push        (commit_push_req),
    .pop         (commit_pop_req),
    .data        (commit_push_data),
    .nxt_entries (w_cmt_entries_nxt),
    .nxt_ptr     (w_cmt_ptr_nxt),
    .nxt_count   (w_cmt_count_nxt)
  );

  // Flush restores from the committed stack's next state so a same-cycle
  // retirement is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spec_entries <= '0;
      r_spec_ptr     <= '0;
      r_spec_count   <= '0;
      r_cmt_entries  <= '0;
      r_cmt_ptr      <= '0;
      r_cmt_count    <= '0;
    end else begin
      r_cmt_entries <= w_cmt_entries_nxt;
      r_cmt_ptr     <= w_cmt_ptr_nxt;
      r_cmt_count   <= w_cmt_count_nxt;
      if (flush) begin
        r_spec_entries <= w_cmt_entries_nxt;
        r_spec_ptr     <= w_cmt_ptr_nxt;
        r_spec_count   <= w_cmt_count_nxt;
      end else begin
        r_spec_entries <= w_spec_entries_nxt;
        r_spec_ptr     <= w_spec_ptr_nxt;
        r_spec_count   <= w_spec_count_nxt;
      end
    end
  end

  assign ras_top.valid = (r_spec_count != '0);
  assign ras_top.data  = ras_top.valid ? r_spec_entries[r_spec_ptr] : '0;
  assign ras_count     = r_spec_count;

endmodule
`default_nettype wire
